// File: rtl/serial_pkg.sv
// Shared definitions for the serial transmitter and its matching receiver:
// frame state encodings and line levels.
package serial_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } serial_state_t;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;

endpackage

// File: rtl/bit_timer.sv
// Bit-period counter: counts clock cycles within one serial bit, flags the
// last cycle of the period and can be restarted synchronously.
module bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clock,
    input  logic clear_n,
    input  logic restart,
    output logic tc
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count;

    assign tc = (count == LAST);

    always_ff @(negedge clock or negedge clear_n) begin
        if (!clear_n) begin
            count <= '0;
        end else if (restart || tc) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/serial_transmitter.sv
// Serial frame transmitter: start bit, LSB-first payload, optional even parity
// (enabled by defining SERIAL_TX_PARITY_EN), stop bit. Updates on falling edges.
module serial_transmitter
    import serial_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                  clock,
    input  logic                  clear_n,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  valid,
    output logic                  ready,
    output logic                  tx,
    output logic                  busy,
    output logic                  done
);

    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

    serial_state_t         state;
    serial_state_t         state_next;
    logic [DATA_WIDTH-1:0] shreg;
    logic [BIT_W-1:0]      bit_cnt;
    logic                  tc;
    logic                  restart;
    logic                  accept;
    logic                  done_next;
`ifdef SERIAL_TX_PARITY_EN
    logic                  parity_bit;
`endif

    assign ready  = (state == ST_IDLE);
    assign busy   = ~ready;
    assign accept = valid && ready;
    // Counter is held at zero while idle so START always gets a full period.
    assign restart = (state_next != state) || (state == ST_IDLE);

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clock  (clock),
        .clear_n(clear_n),
        .restart(restart),
        .tc     (tc)
    );

    always_comb begin
        state_next = state;
        tx         = LINE_IDLE;
        done_next  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) state_next = ST_START;
            end
            ST_START: begin
                tx = LINE_START;
                if (tc) state_next = ST_DATA;
            end
            ST_DATA: begin
                tx = shreg[0];
                if (tc && (bit_cnt == LAST_BIT)) begin
`ifdef SERIAL_TX_PARITY_EN
                    state_next = ST_PARITY;
`else
                    state_next = ST_STOP;
`endif
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            ST_PARITY: begin
                tx = parity_bit;
                if (tc) state_next = ST_STOP;
            end
`endif
            ST_STOP: begin
                if (tc) begin
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(negedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state <= ST_IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            done  <= done_next;
        end
    end

    // Payload is captured on accept and shifted out LSB first.
    always_ff @(negedge clock or negedge clear_n) begin
        if (!clear_n) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else begin
            if (accept) begin
                shreg <= data;
            end else if ((state == ST_DATA) && tc) begin
                shreg <= shreg >> 1;
            end
            if (state != ST_DATA) begin
                bit_cnt <= '0;
            end else if (tc) begin
                bit_cnt <= bit_cnt + BIT_W'(1);
            end
        end
    end

`ifdef SERIAL_TX_PARITY_EN
    always_ff @(negedge clock or negedge clear_n) begin
        if (!clear_n) begin
            parity_bit <= 1'b0;
        end else if (accept) begin
            parity_bit <= ^data;
        end
    end
`endif

endmodule

// File: tb/tb_serial_transmitter.sv
// Directed bench for serial_transmitter (DATA_WIDTH=8, CLKS_PER_BIT=4);
// follows SERIAL_TX_PARITY_EN to select the expected frame format.
module tb_serial_transmitter;

    localparam int DW  = 8;
    localparam int CPB = 4;
`ifdef SERIAL_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int FRAME = (2 + DW + P) * CPB;

    logic          clock   = 1'b0;
    logic          clear_n = 1'b1;
    logic [DW-1:0] data    = '0;
    logic          valid   = 1'b0;
    logic          ready;
    logic          tx;
    logic          busy;
    logic          done;

    int checks = 0;
    int passed = 0;

    serial_transmitter #(
        .DATA_WIDTH  (DW),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clock  (clock),
        .clear_n(clear_n),
        .data   (data),
        .valid  (valid),
        .ready  (ready),
        .tx     (tx),
        .busy   (busy),
        .done   (done)
    );

    always #5 clock = ~clock;

    // Expected line level n cycles after the accepting edge.
    function automatic logic exp_tx(input logic [DW-1:0] d, input int n);
        if (n < 0) return 1'b1;
        if (n < CPB) return 1'b0;
        if (n < (1 + DW) * CPB) return d[(n / CPB) - 1];
        if ((P == 1) && (n < (2 + DW) * CPB)) return ^d;
        return 1'b1;
    endfunction

    task automatic test_reset();
        #1 clear_n = 1'b0;
        #2;
        checks++; if (tx !== 1'b1) $display("FAIL reset_tx got %b want 1", tx); else passed++;
        checks++; if (ready !== 1'b1) $display("FAIL reset_ready got %b want 1", ready); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
        checks++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
        @(posedge clock); #1;
        clear_n = 1'b1;
    endtask

    task automatic test_handshake_idle();
        valid = 1'b0;
        data  = 8'h55;
        for (int n = 0; n < 20; n++) begin
            @(posedge clock); #1;
            checks++; if (tx !== 1'b1) $display("FAIL idle_tx cycle %0d got %b want 1", n, tx); else passed++;
            checks++; if (ready !== 1'b1) $display("FAIL idle_ready cycle %0d got %b want 1", n, ready); else passed++;
            checks++; if (busy !== 1'b0) $display("FAIL idle_busy cycle %0d got %b want 0", n, busy); else passed++;
            checks++; if (done !== 1'b0) $display("FAIL idle_done cycle %0d got %b want 0", n, done); else passed++;
        end
    endtask

    task automatic test_single_frame(input logic [DW-1:0] d);
        data  = d;
        valid = 1'b1;
        @(negedge clock);
        for (int n = 0; n <= FRAME + 1; n++) begin
            @(posedge clock); #1;
            if (n == 0) valid = 1'b0;
            checks++; if (tx !== exp_tx(d, n)) $display("FAIL frame_tx d=%h cycle %0d got %b want %b", d, n, tx, exp_tx(d, n)); else passed++;
            checks++; if (done !== 1'(n == FRAME)) $display("FAIL frame_done d=%h cycle %0d got %b want %b", d, n, done, (n == FRAME)); else passed++;
            checks++; if (ready !== 1'(n >= FRAME)) $display("FAIL frame_ready d=%h cycle %0d got %b want %b", d, n, ready, (n >= FRAME)); else passed++;
            checks++; if (busy !== 1'(n < FRAME)) $display("FAIL frame_busy d=%h cycle %0d got %b want %b", d, n, busy, (n < FRAME)); else passed++;
`ifdef SERIAL_TX_PARITY_EN
            if (d == 8'h07 && n >= 36 && n <= 39) begin
                checks++; if (tx !== 1'b1) $display("FAIL parity_07 cycle %0d got %b want 1", n, tx); else passed++;
            end
            if (d == 8'hA5 && n >= 36 && n <= 39) begin
                checks++; if (tx !== 1'b0) $display("FAIL parity_a5 cycle %0d got %b want 0", n, tx); else passed++;
            end
`endif
        end
    endtask

    task automatic test_ignore_busy();
        data  = 8'h3C;
        valid = 1'b1;
        @(negedge clock);
        for (int n = 0; n <= FRAME; n++) begin
            @(posedge clock); #1;
            checks++; if (tx !== exp_tx(8'h3C, n)) $display("FAIL ignore_tx cycle %0d got %b want %b", n, tx, exp_tx(8'h3C, n)); else passed++;
            checks++; if (done !== 1'(n == FRAME)) $display("FAIL ignore_done cycle %0d got %b want %b", n, done, (n == FRAME)); else passed++;
            if (n == 0) valid = 1'b0;
            if (n == 10) begin
                checks++; if (ready !== 1'b0) $display("FAIL ignore_ready got %b want 0", ready); else passed++;
                valid = 1'b1;
                data  = 8'hFF;
            end
            if (n == FRAME) valid = 1'b0;
        end
        @(posedge clock); #1;
        checks++; if (ready !== 1'b1) $display("FAIL ignore_no_queue ready got %b want 1", ready); else passed++;
    endtask

    task automatic test_back_to_back();
        logic want_tx;
        data  = 8'h01;
        valid = 1'b1;
        @(negedge clock);
        for (int n = 0; n <= 2 * FRAME + 2; n++) begin
            @(posedge clock); #1;
            want_tx = (n <= FRAME) ? exp_tx(8'h01, n) : exp_tx(8'h80, n - FRAME - 1);
            checks++; if (tx !== want_tx) $display("FAIL b2b_tx cycle %0d got %b want %b", n, tx, want_tx); else passed++;
            checks++; if (done !== 1'((n == FRAME) || (n == 2 * FRAME + 1))) $display("FAIL b2b_done cycle %0d got %b", n, done); else passed++;
            if (n == 5) data = 8'h80;
            if (n == FRAME + 1) valid = 1'b0;
        end
    endtask

    task automatic test_reset_mid_frame();
        data  = 8'hA5;
        valid = 1'b1;
        @(negedge clock);
        for (int n = 0; n <= 10; n++) begin
            @(posedge clock); #1;
            if (n == 0) valid = 1'b0;
        end
        #2 clear_n = 1'b0;
        #1;
        checks++; if (tx !== 1'b1) $display("FAIL midrst_tx got %b want 1", tx); else passed++;
        checks++; if (ready !== 1'b1) $display("FAIL midrst_ready got %b want 1", ready); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL midrst_busy got %b want 0", busy); else passed++;
        for (int n = 0; n < 3; n++) begin
            @(posedge clock); #1;
            checks++; if (done !== 1'b0) $display("FAIL midrst_done cycle %0d got %b want 0", n, done); else passed++;
            checks++; if (tx !== 1'b1) $display("FAIL midrst_hold_tx cycle %0d got %b want 1", n, tx); else passed++;
        end
        clear_n = 1'b1;
        data    = 8'h5A;
        valid   = 1'b1;
        @(negedge clock);
        for (int n = 0; n <= FRAME + 1; n++) begin
            @(posedge clock); #1;
            if (n == 0) valid = 1'b0;
            checks++; if (tx !== exp_tx(8'h5A, n)) $display("FAIL postrst_tx cycle %0d got %b want %b", n, tx, exp_tx(8'h5A, n)); else passed++;
            checks++; if (done !== 1'(n == FRAME)) $display("FAIL postrst_done cycle %0d got %b want %b", n, done, (n == FRAME)); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_handshake_idle();
        test_single_frame(8'hA5);
        test_single_frame(8'h07);
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/serial_transmitter.md
SERIAL_TRANSMITTER -- requirements
Module: serial_transmitter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8: number of payload bits per frame.
REQ-002 The block SHALL have parameter CLKS_PER_BIT, default 4: clock cycles per serial bit, minimum 2.
REQ-003 The block SHALL have port clock, input, 1 bit: single clock; all state updates on the falling edge.
REQ-004 The block SHALL have port clear_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port data, input, DATA_WIDTH bits: parallel payload, sampled only on accept.
REQ-006 The block SHALL have port valid, input, 1 bit: the source requests transmission of data.
REQ-007 The block SHALL have port ready, output, 1 bit: the block can accept a new payload.
REQ-008 The block SHALL have port tx, output, 1 bit: serial line, idle high.
REQ-009 The block SHALL have port busy, output, 1 bit: a frame is in progress.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse marking the end of the stop bit.

Function
REQ-011 States SHALL be IDLE, START, DATA, PARITY and STOP, encoded in one registered state variable.
REQ-012 Accept SHALL occur on a falling edge where valid=1 and ready=1; data is copied into an internal shift register at that edge.
REQ-013 ready SHALL be 1 only in IDLE; busy SHALL be the inverse of ready.
REQ-014 State transition on accept: IDLE->START, with tx=0 from that edge for exactly CLKS_PER_BIT cycles.
REQ-015 In DATA, tx SHALL output payload bits LSB first, each held CLKS_PER_BIT cycles, for DATA_WIDTH bits.
REQ-016 After the last data bit, the next state SHALL be PARITY when enabled (REQ-024), else STOP.
REQ-017 STOP SHALL drive tx=1 for CLKS_PER_BIT cycles, then return to IDLE.
REQ-018 done=1 SHALL be asserted for exactly the one cycle in which the STOP->IDLE transition is taken, and 0 otherwise.
REQ-019 Total frame length from accept to IDLE SHALL be (2 + DATA_WIDTH + P) * CLKS_PER_BIT cycles, where P=1 with parity and P=0 without.
REQ-020 valid, and changes on data, while busy=1 SHALL be ignored; no payload is queued.
REQ-021 Back-to-back operation: with valid held high, the next accept SHALL occur on the first edge at which the block is in IDLE (one idle cycle with tx=1 between frames).
REQ-022 The bit-period counter SHALL wrap from CLKS_PER_BIT-1 to 0 and SHALL reset to 0 on every state change.

Reset
REQ-023 clear_n=0 SHALL immediately, independent of clock and including mid-frame, force state=IDLE, tx=1, ready=1, busy=0, done=0, counters=0 and shift register=0; after release the first accept is possible on the next falling edge.

Configuration
REQ-024 Macro SERIAL_TX_PARITY_EN: when defined, the PARITY state SHALL be included and drive even parity (XOR of payload bits) for CLKS_PER_BIT cycles; when undefined, the PARITY state and its logic SHALL be absent and DATA SHALL proceed directly to STOP.

Structure
REQ-025 State encodings and the idle-line level constant SHALL reside in the shared package serial_pkg, for reuse by the matching receiver.
REQ-026 Bit-period timing SHALL be implemented in one sub-module, bit_timer (a counter with a terminal-count output and synchronous restart), instantiated once.

Verification (DATA_WIDTH=8, CLKS_PER_BIT=4)
REQ-027 Reset: clear_n=0 asserted mid-DATA -> tx=1, ready=1, busy=0 before the next clock edge; no done pulse.
REQ-028 Single frame, no parity: data=8'hA5 accepted -> tx sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; done pulses at cycle 40; ready=1 at cycle 40.
REQ-029 Parity build: data=8'h07 -> parity bit 1 at cycles 36-39, stop bit at cycles 40-43, done at cycle 44; data=8'hA5 -> parity bit 0.
REQ-030 Ignore while busy: data=8'h3C accepted, then valid=1 with data=8'hFF at cycle 10 -> frame 1 carries 8'h3C unchanged.
REQ-031 Back-to-back: valid held high with data 8'h01 then 8'h80 -> the second start bit begins exactly one idle cycle after the first done pulse.
REQ-032 Handshake: valid=0 in IDLE for 20 cycles -> tx stays 1, ready stays 1, no state change.
